// File: rtl/vga_text_term.sv
// Character-cell text terminal: a byte-stream writer fills a COLS x ROWS buffer
// that is scanned in step with vga_ctrl coordinates through an external font ROM.
module vga_text_term #(
  parameter int          COLS = 70,
  parameter int          ROWS = 30,
  parameter logic [23:0] FG   = 24'hFFFFFF,
  parameter logic [23:0] BG   = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_addr,
  input  logic [8:0]  v_addr,
  input  logic        wr_valid,
  input  logic [7:0]  wr_char,
  output logic        wr_ready,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic [7:0]  font_ascii,
  output logic [3:0]  font_row,
  output logic [3:0]  font_col,
  input  logic        font_bit,
  output logic [23:0] vga_data,
  output logic        dbg_state
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  // Handshake: a byte moves on a rising edge where wr_valid and wr_ready are both
  // high; wr_ready depends only on state, never on wr_valid or wr_char.
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q;
  logic [AW-1:0] clr_q;
  logic          wr_ready_q;
  logic [4:0]    cur_row_q, cur_row_d;
  logic [6:0]    cur_col_q, cur_col_d;

  logic          accept, printable;
  logic [AW-1:0] cur_addr, wr_addr;
  logic          wr_en;
  logic [7:0]    wr_data;

  logic [7:0]    buf_q [CELLS];

  assign accept    = wr_valid & wr_ready_q;
  assign printable = (wr_char >= 8'h20) && (wr_char <= 8'h7E);
  assign cur_addr  = AW'(cur_row_q) * AW'(COLS) + AW'(cur_col_q);

  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    wr_en     = 1'b0;
    wr_addr   = clr_q;
    wr_data   = 8'h20;
    if (state_q == S_CLEAR) begin
      wr_en = 1'b1;
    end else if (accept) begin
      if (printable) begin
        wr_en   = 1'b1;
        wr_addr = cur_addr;
        wr_data = wr_char;
        if (cur_col_q == 7'(COLS - 1)) begin
          cur_col_d = '0;
          cur_row_d = (cur_row_q == 5'(ROWS - 1)) ? '0 : cur_row_q + 5'd1;
        end else begin
          cur_col_d = cur_col_q + 7'd1;
        end
      end else if (wr_char == 8'h0A) begin
        cur_col_d = '0;
        cur_row_d = (cur_row_q == 5'(ROWS - 1)) ? '0 : cur_row_q + 5'd1;
      end else if ((wr_char == 8'h08) && (cur_addr != '0)) begin
        // Row-major layout makes the previous cell cur_addr-1 even across a line start.
        wr_en   = 1'b1;
        wr_addr = cur_addr - AW'(1);
        if (cur_col_q != '0) begin
          cur_col_d = cur_col_q - 7'd1;
        end else begin
          cur_col_d = 7'(COLS - 1);
          cur_row_d = cur_row_q - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_q      <= '0;
      wr_ready_q <= 1'b0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_q == AW'(CELLS - 1)) begin
            state_q    <= S_RUN;
            wr_ready_q <= 1'b1;
            clr_q      <= '0;
          end else begin
            clr_q <= clr_q + AW'(1);
          end
        end
        S_RUN: begin
          cur_row_q <= cur_row_d;
          cur_col_q <= cur_col_d;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= wr_data;
  end

  // Scan pipeline: cell lookup, font ROM stage, colour register.
  logic          in_text, in_text_q;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data_q;
  logic [3:0]    grow_q, gcol_q;
  logic [23:0]   vga_q;

  assign in_text = (h_addr < 10'(COLS * 9)) && (v_addr < 9'(ROWS * 16));
  assign rd_addr = in_text ? (AW'(v_addr[8:4]) * AW'(COLS) + AW'(h_addr / 10'd9)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      grow_q    <= '0;
      gcol_q    <= '0;
      in_text_q <= 1'b0;
      vga_q     <= '0;
    end else begin
      rd_data_q <= buf_q[rd_addr];
      grow_q    <= v_addr[3:0];
      gcol_q    <= 4'(h_addr % 10'd9);
      in_text_q <= in_text;
      vga_q     <= (in_text_q & font_bit) ? FG : BG;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;
  assign font_ascii = rd_data_q;
  assign font_row   = grow_q;
  assign font_col   = gcol_q;
  assign vga_data   = vga_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vga_text_term.sv
// Bench for vga_text_term: byte-level terminal model, pixel scoreboard and corner vectors.
module tb_vga_text_term;

  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;
  localparam int NC = 70;
  localparam int NR = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  h_addr;
  logic [8:0]  v_addr;
  logic        wr_valid;
  logic [7:0]  wr_char;
  logic        wr_ready;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic [7:0]  font_ascii;
  logic [3:0]  font_row, font_col;
  logic        font_bit;
  logic [23:0] vga_data;
  logic        dbg_state;
  logic        force_one;

  vga_text_term dut (
    .clk(clk), .rst(rst), .h_addr(h_addr), .v_addr(v_addr),
    .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
    .cur_row(cur_row), .cur_col(cur_col),
    .font_ascii(font_ascii), .font_row(font_row), .font_col(font_col),
    .font_bit(font_bit), .vga_data(vga_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Stand-in font ROM: spaces are blank, other glyphs follow a fixed hash.
  function automatic logic font_model(input logic [7:0] a, input logic [3:0] r, input logic [3:0] c);
    int x;
    if (a == 8'h20) return 1'b0;
    x = int'(a) * 7 + int'(r) * 13 + int'(c) * 5;
    return (x % 3) == 0;
  endfunction

  assign font_bit = force_one | font_model(font_ascii, font_row, font_col);

  logic [7:0] model_mem [NC*NR];
  int m_row, m_col;
  int checks = 0;
  int failures = 0;
  int sh_q[$];
  int sv_q[$];

  typedef struct {
    int         h;
    int         v;
    logic       frc;
    logic [3:0] e_row;
    logic [3:0] e_col;
    logic [23:0] e_vga;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit in_text(input int h, input int v);
    return (h < NC*9) && (v < NR*16);
  endfunction

  function automatic logic [7:0] exp_ascii(input int h, input int v);
    if (!in_text(h, v)) return model_mem[0];
    return model_mem[(v/16)*NC + h/9];
  endfunction

  function automatic logic [23:0] exp_pix(input int h, input int v);
    if (!in_text(h, v)) return BG;
    return font_model(model_mem[(v/16)*NC + h/9], 4'(v % 16), 4'(h % 9)) ? FG : BG;
  endfunction

  // Terminal behaviour on a linear cell position.
  task automatic model_write(input logic [7:0] c);
    int pos;
    pos = m_row*NC + m_col;
    if (c >= 8'h20 && c <= 8'h7E) begin
      model_mem[pos] = c;
      pos = (pos + 1) % (NC*NR);
      m_row = pos / NC; m_col = pos % NC;
    end else if (c == 8'h0A) begin
      m_row = (m_row + 1) % NR; m_col = 0;
    end else if (c == 8'h08) begin
      if (pos > 0) begin
        pos--;
        model_mem[pos] = 8'h20;
        m_row = pos / NC; m_col = pos % NC;
      end
    end
  endtask

  task automatic write_byte(input logic [7:0] c);
    int guard;
    guard = 0;
    wr_valid = 1'b1; wr_char = c;
    while (!wr_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!wr_ready) begin
      checks++; failures++;
      $display("FAIL wr_ready_timeout actual=0 required=1");
      wr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    model_write(c);
    check("cur_row", 32'(cur_row), 32'(m_row));
    check("cur_col", 32'(cur_col), 32'(m_col));
  endtask

  task automatic clear_wait();
    int n;
    n = 0;
    while (!wr_ready && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check("clear_cycles", 32'(n), 32'd2100);
    for (int i = 0; i < NC*NR; i++) model_mem[i] = 8'h20;
    m_row = 0; m_col = 0;
  endtask

  // Streams queued coordinates one per cycle; colours are scoreboarded two edges later.
  task automatic run_scan();
    logic [23:0] exp_q[$];
    int n;
    n = sh_q.size();
    for (int i = 0; i <= n; i++) begin
      int h;
      int v;
      h = 0; v = 0;
      if (i < n) begin
        h = sh_q[i]; v = sv_q[i];
        h_addr = 10'(h); v_addr = 9'(v);
        exp_q.push_back(exp_pix(h, v));
      end
      @(posedge clk); #1;
      if (i < n) begin
        check("font_ascii", 32'(font_ascii), 32'(exp_ascii(h, v)));
        check("font_row", 32'(font_row), 32'(v % 16));
        check("font_col", 32'(font_col), 32'(h % 9));
      end
      if (i >= 1) check("vga_data", 32'(vga_data), 32'(exp_q.pop_front()));
    end
    sh_q.delete(); sv_q.delete();
  endtask

  task automatic readback_all();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        sh_q.push_back(c*9 + $urandom_range(0, 8));
        sv_q.push_back(r*16 + $urandom_range(0, 15));
      end
    run_scan();
  endtask

  task automatic random_scan(input int n);
    for (int i = 0; i < n; i++) begin
      sh_q.push_back($urandom_range(0, 639));
      sv_q.push_back($urandom_range(0, 479));
    end
    run_scan();
  endtask

  initial begin
    logic [7:0] old_c, new_c, b;
    int r;
    vecs[0] = '{635, 100, 1'b1, 4'd4,  4'd5, BG};
    vecs[1] = '{10,  479, 1'b1, 4'd15, 4'd1, FG};
    vecs[2] = '{629, 479, 1'b1, 4'd15, 4'd8, FG};
    vecs[3] = '{630, 479, 1'b1, 4'd15, 4'd0, BG};
    vecs[4] = '{639, 0,   1'b1, 4'd0,  4'd0, BG};
    vecs[5] = '{0,   0,   1'b1, 4'd0,  4'd0, FG};
    vecs[6] = '{300, 200, 1'b0, 4'd8,  4'd3, BG};
    vecs[7] = '{10,  479, 1'b0, 4'd15, 4'd1, BG};

    h_addr = '0; v_addr = '0; wr_valid = 1'b0; wr_char = '0; force_one = 1'b0;
    m_row = 0; m_col = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vga_data", 32'(vga_data), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_cur_row", 32'(cur_row), 32'd0);
    check("rst_cur_col", 32'(cur_col), 32'd0);
    check("rst_font_ascii", 32'(font_ascii), 32'd0);
    check("rst_font_row", 32'(font_row), 32'd0);
    check("rst_font_col", 32'(font_col), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    rst = 1'b0;
    clear_wait();
    check("run_state", 32'(dbg_state), 32'd1);
    readback_all();
    random_scan(1500);

    write_byte(8'h41);
    check("A_col", 32'(cur_col), 32'd1);
    for (int v = 0; v < 16; v++)
      for (int h = 0; h < 9; h++) begin
        sh_q.push_back(h); sv_q.push_back(v);
      end
    run_scan();

    write_byte(8'h08);
    repeat (70) write_byte(8'($urandom_range(32, 126)));
    check("after70_row", 32'(cur_row), 32'd1);
    check("after70_col", 32'(cur_col), 32'd0);
    write_byte(8'h0A);
    check("nl_row", 32'(cur_row), 32'd2);
    check("nl_col", 32'(cur_col), 32'd0);
    write_byte(8'h08);
    check("bs_row", 32'(cur_row), 32'd1);
    check("bs_col", 32'(cur_col), 32'd69);
    sh_q.push_back(69*9); sv_q.push_back(16);
    run_scan();
    write_byte(8'h00); write_byte(8'h7F); write_byte(8'h1B); write_byte(8'hC3);

    while (!(m_row == NR-1 && m_col == NC-1)) write_byte(8'($urandom_range(32, 126)));
    write_byte(8'($urandom_range(32, 126)));
    check("wrap_row", 32'(cur_row), 32'd0);
    check("wrap_col", 32'(cur_col), 32'd0);
    write_byte(8'h08);
    check("bs00_row", 32'(cur_row), 32'd0);
    check("bs00_col", 32'(cur_col), 32'd0);
    readback_all();

    // Read and write of the same cell on one edge: the read sees the old byte.
    old_c = model_mem[0];
    new_c = (old_c == 8'h5A) ? 8'h5B : 8'h5A;
    h_addr = '0; v_addr = '0;
    wr_valid = 1'b1; wr_char = new_c;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check("same_cell_old", 32'(font_ascii), 32'(old_c));
    model_write(new_c);
    @(posedge clk); #1;
    check("same_cell_new", 32'(font_ascii), 32'(new_c));
    check("same_cell_col", 32'(cur_col), 32'(m_col));
    random_scan(2000);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_char = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
      end
      r = $urandom_range(0, 19);
      if (r == 0) b = 8'h0A;
      else if (r == 1) b = 8'h08;
      else if (r == 2) b = 8'($urandom_range(127, 255));
      else b = 8'($urandom_range(32, 126));
      write_byte(b);
    end
    random_scan(500);

    wr_valid = 1'b1; wr_char = 8'h41;
    rst = 1'b1;
    #1;
    check("midrun_ready", 32'(wr_ready), 32'd0);
    check("midrun_row", 32'(cur_row), 32'd0);
    check("midrun_col", 32'(cur_col), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    check("midclear_ready", 32'(wr_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_wait();
    wr_valid = 1'b0;
    check("postclear_row", 32'(cur_row), 32'd0);
    check("postclear_col", 32'(cur_col), 32'd0);
    readback_all();

    for (int i = 0; i < 8; i++) begin
      h_addr = 10'(vecs[i].h); v_addr = 9'(vecs[i].v); force_one = vecs[i].frc;
      @(posedge clk); #1;
      check("vec_font_row", 32'(font_row), 32'(vecs[i].e_row));
      check("vec_font_col", 32'(font_col), 32'(vecs[i].e_col));
      check("vec_font_ascii", 32'(font_ascii), 32'(exp_ascii(vecs[i].h, vecs[i].v)));
      @(posedge clk); #1;
      check("vec_vga", 32'(vga_data), 32'(vecs[i].e_vga));
    end
    force_one = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
